// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Integer register file for the RISC-V core with two combinational read
//   ports, one synchronous write-back port and a per-register busy
//   scoreboard that lets decode detect RAW hazards on long-latency results.
//
// Ports
//   clk, rst            clock (rising edge) / asynchronous active-high reset
//   stall               suppresses issue marking only (writes still happen)
//   rs1Addr, rs2Addr    read addresses
//   rs1Data, rs2Data    read data (zero-register masking, optional bypass)
//   rs1Busy, rs2Busy    source register has an outstanding producer
//   wrEn, wrAddr,
//   wrData              write-back port; also retires the busy bit
//   issueEn, issueAddr  marks issueAddr busy (new outstanding producer)
//   pendingCount        number of busy registers (popcount of busy vector)
//   dbgAddr, dbgData    debug read of the stored value, no bypass
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int XLEN     = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [AW-1:0]   rs1Addr,
    input  logic [AW-1:0]   rs2Addr,
    output logic [XLEN-1:0] rs1Data,
    output logic [XLEN-1:0] rs2Data,
    output logic            rs1Busy,
    output logic            rs2Busy,
    input  logic            wrEn,
    input  logic [AW-1:0]   wrAddr,
    input  logic [XLEN-1:0] wrData,
    input  logic            issueEn,
    input  logic [AW-1:0]   issueAddr,
    output logic [AW:0]     pendingCount,
    input  logic [AW-1:0]   dbgAddr,
    output logic [XLEN-1:0] dbgData
);

    localparam int   NREG      = 2 ** AW;
    localparam logic ZERO_EN   = (ZERO_REG != 0);
    localparam logic BYPASS_EN = (BYPASS != 0);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [AW:0]     count;

    logic wr_zero;
    logic iss_zero;
    logic set_busy;
    logic clr_busy;
    logic same_addr;
    logic cnt_inc;
    logic cnt_dec;

    assign wr_zero   = ZERO_EN && (wrAddr == '0);
    assign iss_zero  = ZERO_EN && (issueAddr == '0);
    assign set_busy  = issueEn && !stall && !iss_zero;
    assign clr_busy  = wrEn && !wr_zero;
    assign same_addr = (issueAddr == wrAddr);

    // A retirement to a register that is being re-issued in the same cycle
    // does not reduce the count: the new producer keeps it busy.
    assign cnt_inc = set_busy && !busy[issueAddr];
    assign cnt_dec = clr_busy && busy[wrAddr] && !(set_busy && same_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy  <= '0;
            count <= '0;
        end else begin
            if (clr_busy) begin
                regs[wrAddr] <= wrData;
                busy[wrAddr] <= 1'b0;
            end
            // Placed after the clear so that set wins on a shared address.
            if (set_busy) begin
                busy[issueAddr] <= 1'b1;
            end
            case ({cnt_inc, cnt_dec})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    logic rs1_zero, rs2_zero;
    logic rs1_fwd, rs2_fwd;

    assign rs1_zero = ZERO_EN && (rs1Addr == '0);
    assign rs2_zero = ZERO_EN && (rs2Addr == '0);
    assign rs1_fwd  = BYPASS_EN && clr_busy && (wrAddr == rs1Addr);
    assign rs2_fwd  = BYPASS_EN && clr_busy && (wrAddr == rs2Addr);

    always_comb begin
        rs1Data = regs[rs1Addr];
        if (rs1_fwd) rs1Data = wrData;
        if (rs1_zero) rs1Data = '0;
    end

    always_comb begin
        rs2Data = regs[rs2Addr];
        if (rs2_fwd) rs2Data = wrData;
        if (rs2_zero) rs2Data = '0;
    end

    // A forwarded value is already available, so it is never reported busy.
    assign rs1Busy = busy[rs1Addr] && !rs1_fwd && !rs1_zero;
    assign rs2Busy = busy[rs2Addr] && !rs2_fwd && !rs2_zero;

    assign pendingCount = count;
    assign dbgData      = regs[dbgAddr];

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [4:0]  rs1Addr, rs2Addr, wrAddr, issueAddr, dbgAddr;
    logic [31:0] wrData;
    logic        wrEn, issueEn;

    logic [31:0] rs1Data, rs2Data, dbgData;
    logic        rs1Busy, rs2Busy;
    logic [5:0]  pendingCount;

    logic [31:0] nb_rs1Data, nb_rs2Data, nb_dbgData;
    logic        nb_rs1Busy, nb_rs2Busy;
    logic [5:0]  nb_pendingCount;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.XLEN(32), .AW(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
        .rs1Data(rs1Data), .rs2Data(rs2Data),
        .rs1Busy(rs1Busy), .rs2Busy(rs2Busy),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .issueEn(issueEn), .issueAddr(issueAddr),
        .pendingCount(pendingCount),
        .dbgAddr(dbgAddr), .dbgData(dbgData)
    );

    regfile_scoreboard #(.XLEN(32), .AW(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .stall(stall),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
        .rs1Data(nb_rs1Data), .rs2Data(nb_rs2Data),
        .rs1Busy(nb_rs1Busy), .rs2Busy(nb_rs2Busy),
        .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
        .issueEn(issueEn), .issueAddr(issueAddr),
        .pendingCount(nb_pendingCount),
        .dbgAddr(dbgAddr), .dbgData(nb_dbgData)
    );

    // One clock edge; one-shot controls drop right after it.
    task automatic tick();
        @(posedge clk);
        #1;
        wrEn    = 1'b0;
        issueEn = 1'b0;
        stall   = 1'b0;
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        wrEn = 1'b1; wrAddr = a; wrData = d;
        tick();
    endtask

    task automatic do_issue(input logic [4:0] a);
        issueEn = 1'b1; issueAddr = a;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; wrEn = 1'b0; issueEn = 1'b0;
        rs1Addr = 5'd1; rs2Addr = 5'd2; wrAddr = 5'd0; issueAddr = 5'd0;
        wrData = 32'h0; dbgAddr = 5'd3;
        #3;
        total++; if (rs1Data !== 32'h0) $display("FAIL reset_rs1Data got %h exp %h", rs1Data, 32'h0); else pass_cnt++;
        total++; if (rs2Data !== 32'h0) $display("FAIL reset_rs2Data got %h exp %h", rs2Data, 32'h0); else pass_cnt++;
        total++; if (dbgData !== 32'h0) $display("FAIL reset_dbgData got %h exp %h", dbgData, 32'h0); else pass_cnt++;
        total++; if (pendingCount !== 6'd0) $display("FAIL reset_count got %0d exp 0", pendingCount); else pass_cnt++;
        total++; if (rs1Busy !== 1'b0 || rs2Busy !== 1'b0) $display("FAIL reset_busy got %b%b exp 00", rs1Busy, rs2Busy); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_bypass();
        do_write(5'd5, 32'hAAAA0005);
        do_issue(5'd5);
        total++; if (pendingCount !== 6'd1) $display("FAIL byp_count_issue got %0d exp 1", pendingCount); else pass_cnt++;
        rs1Addr = 5'd5; dbgAddr = 5'd5;
        wrEn = 1'b1; wrAddr = 5'd5; wrData = 32'h1234;
        #1;
        total++; if (rs1Data !== 32'h1234) $display("FAIL byp_rs1Data got %h exp %h", rs1Data, 32'h1234); else pass_cnt++;
        total++; if (dbgData !== 32'hAAAA0005) $display("FAIL byp_dbg_old got %h exp %h", dbgData, 32'hAAAA0005); else pass_cnt++;
        total++; if (nb_rs1Data !== 32'hAAAA0005) $display("FAIL nobyp_rs1Data got %h exp %h", nb_rs1Data, 32'hAAAA0005); else pass_cnt++;
        total++; if (rs1Busy !== 1'b0) $display("FAIL byp_rs1Busy got %b exp 0", rs1Busy); else pass_cnt++;
        total++; if (nb_rs1Busy !== 1'b1) $display("FAIL nobyp_rs1Busy got %b exp 1", nb_rs1Busy); else pass_cnt++;
        tick();
        total++; if (dbgData !== 32'h1234) $display("FAIL byp_dbg_new got %h exp %h", dbgData, 32'h1234); else pass_cnt++;
        total++; if (nb_rs1Data !== 32'h1234) $display("FAIL nobyp_rs1_new got %h exp %h", nb_rs1Data, 32'h1234); else pass_cnt++;
        total++; if (pendingCount !== 6'd0 || nb_pendingCount !== 6'd0) $display("FAIL byp_count_ret got %0d/%0d exp 0", pendingCount, nb_pendingCount); else pass_cnt++;
    endtask

    task automatic test_zero_reg();
        rs1Addr = 5'd0; dbgAddr = 5'd0;
        wrEn = 1'b1; wrAddr = 5'd0; wrData = 32'hFFFFFFFF;
        issueEn = 1'b1; issueAddr = 5'd0;
        #1;
        total++; if (rs1Data !== 32'h0) $display("FAIL x0_rs1Data_pre got %h exp 0", rs1Data); else pass_cnt++;
        tick();
        total++; if (rs1Data !== 32'h0) $display("FAIL x0_rs1Data got %h exp 0", rs1Data); else pass_cnt++;
        total++; if (dbgData !== 32'h0) $display("FAIL x0_dbgData got %h exp 0", dbgData); else pass_cnt++;
        total++; if (rs1Busy !== 1'b0) $display("FAIL x0_busy got %b exp 0", rs1Busy); else pass_cnt++;
        total++; if (pendingCount !== 6'd0) $display("FAIL x0_count got %0d exp 0", pendingCount); else pass_cnt++;
    endtask

    task automatic test_issue_stall();
        rs2Addr = 5'd7; dbgAddr = 5'd7;
        do_issue(5'd7);
        total++; if (rs2Busy !== 1'b1) $display("FAIL iss7_busy got %b exp 1", rs2Busy); else pass_cnt++;
        total++; if (pendingCount !== 6'd1) $display("FAIL iss7_count got %0d exp 1", pendingCount); else pass_cnt++;
        do_issue(5'd7);
        total++; if (pendingCount !== 6'd1) $display("FAIL waw7_count got %0d exp 1", pendingCount); else pass_cnt++;
        do_write(5'd7, 32'h70);
        total++; if (rs2Busy !== 1'b0) $display("FAIL wr7_busy got %b exp 0", rs2Busy); else pass_cnt++;
        total++; if (pendingCount !== 6'd0) $display("FAIL wr7_count got %0d exp 0", pendingCount); else pass_cnt++;
        stall = 1'b1;
        do_issue(5'd7);
        total++; if (rs2Busy !== 1'b0) $display("FAIL stall7_busy got %b exp 0", rs2Busy); else pass_cnt++;
        total++; if (pendingCount !== 6'd0) $display("FAIL stall7_count got %0d exp 0", pendingCount); else pass_cnt++;
        stall = 1'b1;
        do_write(5'd7, 32'h77);
        total++; if (dbgData !== 32'h77) $display("FAIL stall_write got %h exp %h", dbgData, 32'h77); else pass_cnt++;
        do_write(5'd8, 32'h88);
        total++; if (pendingCount !== 6'd0) $display("FAIL wr_notbusy_count got %0d exp 0", pendingCount); else pass_cnt++;
    endtask

    task automatic test_same_cycle();
        rs1Addr = 5'd9; dbgAddr = 5'd9;
        do_issue(5'd9);
        issueEn = 1'b1; issueAddr = 5'd9;
        wrEn = 1'b1; wrAddr = 5'd9; wrData = 32'h99;
        #1;
        total++; if (rs1Busy !== 1'b0) $display("FAIL same9_byp_busy got %b exp 0", rs1Busy); else pass_cnt++;
        total++; if (nb_rs1Busy !== 1'b1) $display("FAIL same9_nobyp_busy got %b exp 1", nb_rs1Busy); else pass_cnt++;
        tick();
        total++; if (rs1Busy !== 1'b1) $display("FAIL same9_busy got %b exp 1", rs1Busy); else pass_cnt++;
        total++; if (pendingCount !== 6'd1) $display("FAIL same9_count got %0d exp 1", pendingCount); else pass_cnt++;
        total++; if (dbgData !== 32'h99) $display("FAIL same9_data got %h exp %h", dbgData, 32'h99); else pass_cnt++;
        do_issue(5'd4);
        total++; if (pendingCount !== 6'd2) $display("FAIL iss4_count got %0d exp 2", pendingCount); else pass_cnt++;
        issueEn = 1'b1; issueAddr = 5'd3;
        wrEn = 1'b1; wrAddr = 5'd4; wrData = 32'h44;
        tick();
        rs1Addr = 5'd3; rs2Addr = 5'd4;
        #1;
        total++; if (rs1Busy !== 1'b1) $display("FAIL x3_busy got %b exp 1", rs1Busy); else pass_cnt++;
        total++; if (rs2Busy !== 1'b0) $display("FAIL x4_busy got %b exp 0", rs2Busy); else pass_cnt++;
        total++; if (pendingCount !== 6'd2) $display("FAIL x3x4_count got %0d exp 2", pendingCount); else pass_cnt++;
        do_write(5'd9, 32'h9);
        do_write(5'd3, 32'h3);
        total++; if (pendingCount !== 6'd0) $display("FAIL drain_count got %0d exp 0", pendingCount); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int bad_up = 0;
        int bad_dn = 0;
        for (int i = 1; i < 32; i++) begin
            do_issue(5'(i));
            rs1Addr = 5'(i);
            #1;
            total++;
            if (pendingCount !== 6'(i) || rs1Busy !== 1'b1) begin
                $display("FAIL ramp_up_%0d got count %0d busy %b exp %0d 1", i, pendingCount, rs1Busy, i);
                bad_up++;
            end else pass_cnt++;
        end
        for (int i = 31; i > 0; i--) begin
            do_write(5'(i), 32'(i) * 32'h01010101);
            rs1Addr = 5'(i); dbgAddr = 5'(i);
            #1;
            total++;
            if (pendingCount !== 6'(i - 1) || rs1Busy !== 1'b0 || dbgData !== 32'(i) * 32'h01010101) begin
                $display("FAIL ramp_dn_%0d got count %0d busy %b data %h exp %0d 0 %h",
                         i, pendingCount, rs1Busy, dbgData, i - 1, 32'(i) * 32'h01010101);
                bad_dn++;
            end else pass_cnt++;
        end
        if (bad_up + bad_dn > 0) $display("ramp errors up %0d down %0d", bad_up, bad_dn);
    endtask

    task automatic test_reset_midrun();
        do_write(5'd1, 32'hDEADBEEF);
        do_write(5'd2, 32'hDEADBEEF);
        do_write(5'd3, 32'hDEADBEEF);
        do_issue(5'd1);
        do_issue(5'd2);
        do_issue(5'd3);
        rs1Addr = 5'd1; rs2Addr = 5'd2; dbgAddr = 5'd3;
        #1;
        total++; if (pendingCount !== 6'd3 || rs1Data !== 32'hDEADBEEF) $display("FAIL pre_rst got count %0d data %h exp 3 deadbeef", pendingCount, rs1Data); else pass_cnt++;
        rst = 1'b1;
        #1;
        total++; if (rs1Data !== 32'h0) $display("FAIL async_rst_rs1Data got %h exp 0", rs1Data); else pass_cnt++;
        total++; if (pendingCount !== 6'd0) $display("FAIL async_rst_count got %0d exp 0", pendingCount); else pass_cnt++;
        total++; if (rs1Busy !== 1'b0 || rs2Busy !== 1'b0) $display("FAIL async_rst_busy got %b%b exp 00", rs1Busy, rs2Busy); else pass_cnt++;
        total++; if (dbgData !== 32'h0) $display("FAIL async_rst_dbg got %h exp 0", dbgData); else pass_cnt++;
        wrEn = 1'b1; wrAddr = 5'd3; wrData = 32'h5;
        issueEn = 1'b1; issueAddr = 5'd2;
        tick();
        rst = 1'b0;
        #1;
        total++; if (dbgData !== 32'h0) $display("FAIL rst_drop_write got %h exp 0", dbgData); else pass_cnt++;
        total++; if (pendingCount !== 6'd0 || rs2Busy !== 1'b0) $display("FAIL rst_drop_issue got %0d %b exp 0 0", pendingCount, rs2Busy); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_bypass();
        test_zero_reg();
        test_issue_stall();
        test_same_cycle();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
